imem_fetch_port: RTL
====================

# imem_fetch_port

Parametrised, synchronous instruction memory for the pipelined core's IF stage. Replaces the combinational instruction ROM with a registered one-cycle fetch port that supports a request/valid handshake, stall and flush, plus a program-load write port. Illegal fetch addresses produce an in-band fault and a NOP. After reset it auto-initialises every word to NOP before accepting any traffic.

## Interface
- XLEN, 32: instruction and data width in bits.
- ADDR_W, 32: byte-address width.
- DEPTH_WORDS, 256: number of XLEN words. Must be a power of two and at least 2.
- NOP_INSTR, 32'h00000013: fill and fault word (addi x0,x0,0).
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address of the instruction.
- fetch_ready  out  1  request accepted this cycle when high together with fetch_req.
- stall  in  1  IF stall; holds the output registers.
- flush  in  1  kills the in-flight fetch.
- fetch_valid  out  1  the fetch_instr, fetch_pc and fetch_fault outputs hold a result.
- fetch_instr  out  XLEN  fetched word.
- fetch_pc  out  ADDR_W  address of the returned word.
- fetch_fault  out  2  fault code: 00 none, 01 misaligned, 10 out of range.
- ld_we  in  1  program-load write enable.
- ld_addr  in  ADDR_W  byte address of the load. Bits [1:0] are ignored.
- ld_data  in  XLEN  load data.
- ld_ready  out  1  load port accepting writes.
- init_done  out  1  initialisation complete.

## Operation
- States are INIT and RUN. Reset forces INIT with the init counter at 0.
- INIT:
  - Writes NOP_INSTR to word[cnt] each cycle, then increments cnt.
  - When cnt reaches DEPTH_WORDS-1, the machine writes that word and moves to RUN on the next edge.
  - fetch_ready, ld_ready and init_done are all 0. fetch_req and ld_we are ignored.
- RUN:
  - init_done=1 and ld_ready=1.
  - fetch_ready = !stall && !flush.
- Fetch acceptance (fetch_req && fetch_ready):
  - The word index is fetch_addr[clog2(DEPTH_WORDS)+1:2].
  - Misaligned (fetch_addr[1:0]≠0): fault 01, instr NOP_INSTR.
  - Otherwise out of range (fetch_addr[ADDR_W-1:2] ≥ DEPTH_WORDS): fault 10, instr NOP_INSTR. There is no wrap-around.
  - Otherwise: fault 00, instr = word[index].
  - Misaligned takes priority over out of range.
- Load: when ld_we is high in RUN, word[ld_addr index] is written with ld_data. Out-of-range load addresses are dropped silently.
- A load and a fetch to the same word in the same cycle return the old data (read-first).

## Timing
- Reset values:
  - fetch_valid=0, fetch_instr=NOP_INSTR, fetch_pc=0, fetch_fault=00.
  - fetch_ready=0, ld_ready=0, init_done=0.
- INIT lasts exactly DEPTH_WORDS cycles after reset deasserts. init_done rises at the following edge.
- Fetch latency is 1 cycle. A request accepted at edge N shows its result at edge N+1 with fetch_valid=1.
- If stall=1, all fetch_* output registers hold their values and no request is accepted.
- If flush=1, fetch_valid clears at the next edge and any request in that cycle is dropped. flush takes priority over stall.
- If no request is accepted and neither stall nor flush is asserted, fetch_valid clears at the next edge.
- Reset asserted mid-operation aborts everything:
  - The machine returns to INIT and outputs take their reset values.
  - Memory is re-filled with NOP, so previously loaded program contents are lost.

## Structure
- imem_pkg holds:
  - state enum (INIT, RUN);
  - fault codes FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE;
  - the default NOP constant.
- Sub-module imem_ram_1r1w: DEPTH_WORDS × XLEN array, one synchronous read port, one write port, read-first. The init sequencer and the load port share its write port through a mux; INIT owns it.
- Top level contains the FSM, init counter, address decode and fault logic, and the output registers.

## Test plan
- Init: reset 1 cycle, DEPTH_WORDS=16. init_done rises exactly 16 cycles after reset falls. A fetch at 0x3C then returns 32'h00000013 with fault 00.
- Load/fetch: write 0x00000133 to address 0x8, then fetch 0x8. fetch_valid=1 one cycle later with instr 0x00000133 and fetch_pc 0x8.
- Faults: fetch 0x6 gives fault 01 with NOP. Fetch 0x40 (DEPTH_WORDS=16) gives fault 10 with NOP. A load to 0x40 leaves every word unchanged.
- Stall/flush: fetch 0x8, then stall for 3 cycles. Outputs hold 0x00000133 and fetch_ready=0. Assert flush with req 0xC: fetch_valid=0 next cycle and the request is not returned.
- Same-cycle write/read: word 0x4 holds A. Write B to 0x4 while fetching 0x4: result is A. The next fetch of 0x4 returns B.
- Reset mid-run: assert reset after loading words. fetch_valid goes to 0, INIT re-runs, and a fetch of the loaded address afterwards returns NOP.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory fetch port
package imem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/imem_ram_1r1w.sv
// rtl/imem_ram_1r1w.sv - word array with one registered read port and one write port, read-first
module imem_ram_1r1w #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 256,
    parameter int              AW         = $clog2(DEPTH),
    parameter logic [XLEN-1:0] RESET_WORD = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the read register is reset; the array is cleared by the init sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= RESET_WORD;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - registered instruction fetch port with auto-init, load port and fault decode
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              ADDR_W      = 32,
    parameter int              DEPTH_WORDS = 256,
    parameter logic [XLEN-1:0] NOP_INSTR   = NOP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    input  logic              stall,
    input  logic              flush,
    output logic              fetch_valid,
    output logic [XLEN-1:0]   fetch_instr,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic [1:0]        fetch_fault,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(DEPTH_WORDS);

    state_e            state;
    logic [IDX_W-1:0]  cnt;
    fault_e            fault_r;
    fault_e            fault_code;
    logic              running;
    logic              accept;
    logic [ADDR_W-1:0] fetch_word;
    logic [ADDR_W-1:0] ld_word;
    logic              ld_in_range;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_waddr;
    logic [XLEN-1:0]   ram_wdata;
    logic [XLEN-1:0]   ram_rdata;

    assign running     = (state == ST_RUN);
    assign fetch_ready = running && !stall && !flush;
    assign ld_ready    = running;
    assign init_done   = running;
    assign accept      = fetch_req && fetch_ready;

    // Word-granular addresses; the full upper range is compared so there is no wrap-around.
    assign fetch_word  = fetch_addr >> 2;
    assign ld_word     = ld_addr >> 2;
    assign ld_in_range = (ld_word < DEPTH_LIM);

    always_comb begin
        fault_code = FAULT_NONE;
        if (fetch_addr[1:0] != 2'b00) begin
            fault_code = FAULT_MISALIGN;
        end else if (fetch_word >= DEPTH_LIM) begin
            fault_code = FAULT_RANGE;
        end
    end

    // INIT owns the write port; afterwards it belongs to the program loader.
    always_comb begin
        ram_we    = 1'b1;
        ram_waddr = cnt;
        ram_wdata = NOP_INSTR;
        if (running) begin
            ram_we    = ld_we && ld_in_range;
            ram_waddr = ld_word[IDX_W-1:0];
            ram_wdata = ld_data;
        end
    end

    imem_ram_1r1w #(
        .XLEN       (XLEN),
        .DEPTH      (DEPTH_WORDS),
        .AW         (IDX_W),
        .RESET_WORD (NOP_INSTR)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (accept),
        .raddr (fetch_word[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            cnt         <= '0;
            fetch_valid <= 1'b0;
            fetch_pc    <= '0;
            fault_r     <= FAULT_NONE;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        fetch_valid <= 1'b0;
                    end else if (stall) begin
                        fetch_valid <= fetch_valid;
                    end else if (accept) begin
                        fetch_valid <= 1'b1;
                        fetch_pc    <= fetch_addr;
                        fault_r     <= fault_code;
                    end else begin
                        fetch_valid <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // Faulted fetches substitute NOP over whatever the array read returned.
    assign fetch_instr = (fault_r == FAULT_NONE) ? ram_rdata : NOP_INSTR;
    assign fetch_fault = fault_r;

endmodule
